// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the two requester ports and the shared memory bus that the
//   mem_bus_arbiter sits between.
//   Modports:
//     slave  : the arbiter view (requests and mem_rdata in, grants/acks/bus out)
//     master : the requester + memory-model view (the mirror image)
//   Signals:
//     m0_* / m1_*  port 0 (cpu) / port 1 (DMA): req, rw, addr, wdata, gnt, ack
//     rdata        registered read data returned with ack
//     mem_en, mem_rw, mem_addr, mem_wdata   registered memory bus outputs
//     mem_rdata    memory read data
//     busy         arbiter is not idle
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Port 0 (cpu core)
    logic          m0_req;
    logic          m0_rw;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_ack;

    // Port 1 (DMA / IO engine)
    logic          m1_req;
    logic          m1_rw;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_ack;

    // Shared return data and memory bus
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_ack, m1_gnt, m1_ack,
        output rdata, mem_en, mem_rw, mem_addr, mem_wdata, busy
    );

    modport master (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_ack, m1_gnt, m1_ack,
        input  rdata, mem_en, mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one 32-bit memory bus between port 0 (cpu) and port 1 (DMA/IO).
//   Each access holds mem_en for WAIT_CYCLES cycles, then returns a one-cycle
//   ack (with rdata for reads). Sequence: IDLE -> ACCESS -> ACK -> IDLE, so
//   peak throughput is one access per WAIT_CYCLES+2 cycles.
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous, active-low reset
//     bus          mem_bus_arbiter_if.slave (requester ports + memory bus)
//   Parameters:
//     AW, DW       address / data width
//     WAIT_CYCLES  mem_en cycles per access, 1..15
//   Configuration macro:
//     ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a tie
//                        undefined -> round-robin on ties (default)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_arbiter_if.slave    bus
);

    localparam int unsigned CW = 4;  // holds WAIT_CYCLES-1 for 1..15

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic [CW-1:0]   cnt_q,        cnt_d;
    logic            owner_q,      owner_d;
    logic            last_owner_q, last_owner_d;
    logic [1:0]      gnt_q,        gnt_d;
    logic [1:0]      ack_q,        ack_d;
    logic            mem_en_q,     mem_en_d;
    logic            mem_rw_q,     mem_rw_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [DW-1:0]   rdata_q,      rdata_d;
    logic            busy_q,       busy_d;

    logic [1:0]      req_vec_c;
    logic            win_c;

    assign req_vec_c = {bus.m1_req, bus.m0_req};

    // Winner selection: a lone requester wins; a tie goes by policy
    always_comb begin
        win_c = 1'b0;
        if (req_vec_c == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            win_c = 1'b0;
`else
            win_c = ~last_owner_q;
`endif
        end else begin
            win_c = req_vec_c[1];
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        ack_d        = ack_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req_vec_c) begin
                    // Latch the winner's request so later changes on its
                    // port cannot disturb the access in flight
                    owner_d     = win_c;
                    gnt_d       = win_c ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = win_c ? bus.m1_rw    : bus.m0_rw;
                    mem_addr_d  = win_c ? bus.m1_addr  : bus.m0_addr;
                    mem_wdata_d = win_c ? bus.m1_wdata : bus.m0_wdata;
                    cnt_d       = CW'(WAIT_CYCLES - 1);
                    state_d     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last mem_en cycle: capture read data and complete
                    if (mem_rw_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    mem_en_d     = 1'b0;
                    ack_d        = gnt_q;
                    last_owner_d = owner_q;
                    state_d      = S_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_ACK: begin
                gnt_d   = 2'b00;
                ack_d   = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d    = 2'b00;
                ack_d    = 2'b00;
                mem_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.m0_gnt    = gnt_q[0];
    assign bus.m1_gnt    = gnt_q[1];
    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

    // Grants are one-hot or zero, and ack never appears without its grant
    a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset)
        gnt_q != 2'b11);
    a_ack_with_gnt: assert property (@(posedge clock) disable iff (!reset)
        (ack_q & ~gnt_q) == 2'b00);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Self-checking bench: one arbiter with WAIT_CYCLES=1 for directed and
//   randomized traffic, one with WAIT_CYCLES=3 for timing checks.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b3)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state
    int            exp_last_owner = 1;
    logic [DW-1:0] exp_rdata      = '0;
    int            grant_log[$];
    logic          p_rw    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return FIXED ? 0 : ((exp_last_owner == 0) ? 1 : 0);
        return r0 ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input int p);
        p_rw[p]    = 1'($urandom_range(0, 1));
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
        if (p == 0) begin
            b1.m0_req = 1'b1; b1.m0_rw = p_rw[0]; b1.m0_addr = p_addr[0]; b1.m0_wdata = p_wdata[0];
        end else begin
            b1.m1_req = 1'b1; b1.m1_rw = p_rw[1]; b1.m1_addr = p_addr[1]; b1.m1_wdata = p_wdata[1];
        end
    endtask

    task automatic disarm(input int p);
        if (p == 0) b1.m0_req = 1'b0;
        else        b1.m1_req = 1'b0;
    endtask

    // Serve pending requests on the WAIT_CYCLES=1 arbiter, checking each access.
    // Must be entered in an IDLE cycle. rearm keeps the winner requesting with a
    // fresh payload; drop_early lowers the winner's req right after the grant.
    task automatic serve(input int n_acc, input bit rearm, input bit drop_early);
        int            done;
        int            w;
        logic [DW-1:0] rd;
        done = 0;
        while (done < n_acc && (b1.m0_req || b1.m1_req)) begin
            w = pick(b1.m0_req, b1.m1_req);
            tick();  // grant edge
            checks++;
            if ({b1.m0_gnt, b1.m1_gnt, b1.mem_en, b1.busy, b1.m0_ack, b1.m1_ack} !== {w == 0, w == 1, 1'b1, 1'b1, 2'b00}) begin
                $display("FAIL grant: got gnt0/gnt1/en/busy/ack0/ack1=%b%b%b%b%b%b want winner %0d granted, en=1 busy=1 no ack",
                         b1.m0_gnt, b1.m1_gnt, b1.mem_en, b1.busy, b1.m0_ack, b1.m1_ack, w);
            end else passed++;
            checks++;
            if ({b1.mem_rw, b1.mem_addr, b1.mem_wdata} !== {p_rw[w], p_addr[w], p_wdata[w]}) begin
                $display("FAIL bus_payload: got rw=%b addr=%h wdata=%h want rw=%b addr=%h wdata=%h",
                         b1.mem_rw, b1.mem_addr, b1.mem_wdata, p_rw[w], p_addr[w], p_wdata[w]);
            end else passed++;
            grant_log.push_back(w);
            if (drop_early) begin
                // Drop and scramble the request; the registered copy must hold
                disarm(w);
                if (w == 0) begin b1.m0_addr = ~p_addr[0]; b1.m0_rw = ~p_rw[0]; end
                else        begin b1.m1_addr = ~p_addr[1]; b1.m1_rw = ~p_rw[1]; end
            end
            rd = $urandom;
            b1.mem_rdata = rd;
            tick();  // completion edge
            if (p_rw[w]) exp_rdata = rd;
            checks++;
            if ({b1.m0_ack, b1.m1_ack, b1.m0_gnt, b1.m1_gnt, b1.mem_en} !== {w == 0, w == 1, w == 0, w == 1, 1'b0} ||
                b1.rdata !== exp_rdata) begin
                $display("FAIL ack: got ack0/ack1/gnt0/gnt1/en=%b%b%b%b%b rdata=%h want port %0d acked, en=0 rdata=%h",
                         b1.m0_ack, b1.m1_ack, b1.m0_gnt, b1.m1_gnt, b1.mem_en, b1.rdata, w, exp_rdata);
            end else passed++;
            exp_last_owner = w;
            done++;
            if (rearm && !drop_early) arm(w);
            else                      disarm(w);
            b1.mem_rdata = $urandom;
            tick();  // back to IDLE
            checks++;
            if ({b1.m0_gnt, b1.m1_gnt, b1.m0_ack, b1.m1_ack, b1.mem_en, b1.busy} !== 6'b0 || b1.rdata !== exp_rdata) begin
                $display("FAIL idle_gap: got gnt0/gnt1/ack0/ack1/en/busy=%b%b%b%b%b%b rdata=%h want all 0 rdata=%h",
                         b1.m0_gnt, b1.m1_gnt, b1.m0_ack, b1.m1_ack, b1.mem_en, b1.busy, b1.rdata, exp_rdata);
            end else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({b1.m0_gnt, b1.m1_gnt, b1.m0_ack, b1.m1_ack, b1.mem_en, b1.busy, b1.mem_rw} !== 7'b0000001 ||
            b1.mem_addr !== '0 || b1.mem_wdata !== '0 || b1.rdata !== '0) begin
            $display("FAIL reset_values: got gnt/ack/en/busy/rw=%b%b%b%b%b%b%b addr=%h wdata=%h rdata=%h want 0000001 and zeros",
                     b1.m0_gnt, b1.m1_gnt, b1.m0_ack, b1.m1_ack, b1.mem_en, b1.busy, b1.mem_rw,
                     b1.mem_addr, b1.mem_wdata, b1.rdata);
        end else passed++;
        @(posedge clock); #2;
        reset = 1'b1;
        // One complete port 0 access moves last_owner to 0
        arm(0);
        serve(1, 0, 0);
        // Start another access and abandon it with reset
        arm(0);
        tick();
        checks++;
        if (b1.mem_en !== 1'b1 || b1.m0_gnt !== 1'b1) begin
            $display("FAIL reset_pre: got en=%b gnt0=%b want 1 1", b1.mem_en, b1.m0_gnt);
        end else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if ({b1.mem_en, b1.m0_gnt, b1.m1_gnt, b1.busy, b1.m0_ack, b1.m1_ack} !== 6'b0) begin
            $display("FAIL reset_mid_access: got en/gnt0/gnt1/busy/ack0/ack1=%b%b%b%b%b%b want 000000",
                     b1.mem_en, b1.m0_gnt, b1.m1_gnt, b1.busy, b1.m0_ack, b1.m1_ack);
        end else passed++;
        exp_last_owner = 1;
        exp_rdata      = '0;
        arm(1);
        #1;
        reset = 1'b1;
        grant_log.delete();
        serve(1, 0, 0);
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            $display("FAIL reset_first_tie: got winner %0d want 0", (grant_log.size() > 0) ? grant_log[0] : -1);
        end else passed++;
        serve(1, 0, 0);
    endtask

    task automatic test_single_read();
        b1.m0_req = 1'b1; b1.m0_rw = 1'b1; b1.m0_addr = 32'h10; b1.m0_wdata = '0;
        b1.mem_rdata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({b1.mem_en, b1.m0_gnt, b1.m0_ack, b1.mem_rw} !== 4'b1101 || b1.mem_addr !== 32'h10) begin
            $display("FAIL read_access: got en/gnt0/ack0/rw=%b%b%b%b addr=%h want 1101 addr=00000010",
                     b1.mem_en, b1.m0_gnt, b1.m0_ack, b1.mem_rw, b1.mem_addr);
        end else passed++;
        tick();
        checks++;
        if ({b1.m0_ack, b1.mem_en} !== 2'b10 || b1.rdata !== 32'hDEADBEEF) begin
            $display("FAIL read_ack: got ack0=%b en=%b rdata=%h want ack0=1 en=0 rdata=deadbeef",
                     b1.m0_ack, b1.mem_en, b1.rdata);
        end else passed++;
        b1.m0_req = 1'b0;
        exp_rdata      = 32'hDEADBEEF;
        exp_last_owner = 0;
        tick();
        checks++;
        if (b1.m0_ack !== 1'b0 || b1.m0_gnt !== 1'b0 || b1.rdata !== 32'hDEADBEEF) begin
            $display("FAIL read_after: got ack0=%b gnt0=%b rdata=%h want 0 0 deadbeef", b1.m0_ack, b1.m0_gnt, b1.rdata);
        end else passed++;
    endtask

    task automatic test_write();
        int acks;
        acks = 0;
        b1.m1_req = 1'b1; b1.m1_rw = 1'b0; b1.m1_addr = 32'h20; b1.m1_wdata = 32'h12345678;
        b1.mem_rdata = 32'hCAFEF00D;
        tick();
        checks++;
        if ({b1.mem_en, b1.m1_gnt, b1.mem_rw} !== 3'b110 || b1.mem_addr !== 32'h20 || b1.mem_wdata !== 32'h12345678) begin
            $display("FAIL write_bus: got en/gnt1/rw=%b%b%b addr=%h wdata=%h want 110 addr=00000020 wdata=12345678",
                     b1.mem_en, b1.m1_gnt, b1.mem_rw, b1.mem_addr, b1.mem_wdata);
        end else passed++;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (b1.m1_ack === 1'b1) acks++;
            if (c == 0) b1.m1_req = 1'b0;
        end
        exp_last_owner = 1;
        checks++;
        if (acks != 1 || b1.rdata !== 32'hDEADBEEF) begin
            $display("FAIL write_ack: got %0d acks rdata=%h want 1 ack rdata=deadbeef", acks, b1.rdata);
        end else passed++;
    endtask

    task automatic test_contention();
        int exp_order[4];
        grant_log.delete();
        arm(0);
        arm(1);
        serve(4, 1, 0);
        disarm(0);
        disarm(1);
        for (int i = 0; i < 4; i++) exp_order[i] = FIXED ? 0 : (i % 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log.size() <= i || grant_log[i] != exp_order[i]) begin
                $display("FAIL contention_order[%0d]: got %0d want %0d", i,
                         (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);
            end else passed++;
        end
        tick();
    endtask

    task automatic test_early_drop();
        int acks;
        acks = 0;
        arm(0);
        serve(1, 0, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (b1.m0_ack === 1'b1 || b1.m0_gnt === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            $display("FAIL early_drop_extra: got %0d extra gnt/ack cycles want 0", acks);
        end else passed++;
    endtask

    task automatic test_random();
        int mask;
        for (int r = 0; r < 30; r++) begin
            mask = $urandom_range(1, 3);
            if (mask[0]) arm(0);
            if (mask[1]) arm(1);
            serve(2, 0, 1'($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_wait3();
        logic [DW-1:0] prev_rd;
        logic [DW-1:0] exp_rd3;
        int            ph;
        exp_rd3 = '0;
        prev_rd = '0;
        b3.m0_req = 1'b1; b3.m0_rw = 1'b1; b3.m0_addr = 32'h30; b3.m0_wdata = '0;
        b3.mem_rdata = prev_rd;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ph = c % 5;
            if (ph == 4) exp_rd3 = prev_rd;
            checks++;
            if (b3.mem_en !== (ph >= 1 && ph <= 3) || b3.m0_ack !== (ph == 4) ||
                b3.m0_gnt !== (ph != 0) || b3.rdata !== exp_rd3) begin
                $display("FAIL wait3_cycle%0d: got en=%b ack=%b gnt=%b rdata=%h want en=%b ack=%b gnt=%b rdata=%h",
                         c, b3.mem_en, b3.m0_ack, b3.m0_gnt, b3.rdata,
                         (ph >= 1 && ph <= 3), (ph == 4), (ph != 0), exp_rd3);
            end else passed++;
            prev_rd = $urandom;
            b3.mem_rdata = prev_rd;
            if (c == 14) b3.m0_req = 1'b0;
        end
        tick();
        checks++;
        if (b3.busy !== 1'b0 || b3.mem_en !== 1'b0 || b3.mem_addr !== 32'h30) begin
            $display("FAIL wait3_end: got busy=%b en=%b addr=%h want 0 0 00000030", b3.busy, b3.mem_en, b3.mem_addr);
        end else passed++;
    endtask

    initial begin
        b1.m0_req = 1'b0; b1.m0_rw = 1'b1; b1.m0_addr = '0; b1.m0_wdata = '0;
        b1.m1_req = 1'b0; b1.m1_rw = 1'b1; b1.m1_addr = '0; b1.m1_wdata = '0;
        b1.mem_rdata = '0;
        b3.m0_req = 1'b0; b3.m0_rw = 1'b1; b3.m0_addr = '0; b3.m0_wdata = '0;
        b3.m1_req = 1'b0; b3.m1_rw = 1'b1; b3.m1_addr = '0; b3.m1_wdata = '0;
        b3.mem_rdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_early_drop();
        test_random();
        test_wait3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
